// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-master RAM arbiter.
// Address/data widths match the 1024x8 single-port RAM.
package ram_arbiter_pkg;

    localparam int unsigned RAM_AW = 10;
    localparam int unsigned RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic rr_last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = REQ_A;
        if (req_a && req_b) begin
            winner = (rr_last == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates requesters A and B onto a single-port RAM, one access per grant.
// Every output is a register; the FSM owns all of them.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = RAM_AW,
    parameter int unsigned DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic          ack_a,
    output logic          rvalid_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic          ack_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_datain,
    input  logic [DW-1:0] ram_dataout,
    output logic          busy
);

    state_e state_q;
    logic   rr_last_q;
    logic   owner_q;
    logic   we_q;
    logic   arb_valid;
    logic   arb_winner;

    rr_arb2 u_rr_arb2 (
        .req_a   (req_a),
        .req_b   (req_b),
        .rr_last (rr_last_q),
        .valid   (arb_valid),
        .winner  (arb_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_last_q   <= REQ_B;
            owner_q     <= REQ_A;
            we_q        <= 1'b0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            rvalid_a    <= 1'b0;
            rvalid_b    <= 1'b0;
            rdata       <= '0;
            ram_en      <= 1'b0;
            ram_address <= '0;
            ram_datain  <= '0;
            busy        <= 1'b0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        owner_q   <= arb_winner;
                        rr_last_q <= arb_winner;
                        if (arb_winner == REQ_A) begin
                            we_q        <= we_a;
                            ram_en      <= we_a;
                            ram_address <= addr_a;
                            ram_datain  <= wdata_a;
                            gnt_a       <= 1'b1;
                        end else begin
                            we_q        <= we_b;
                            ram_en      <= we_b;
                            ram_address <= addr_b;
                            ram_datain  <= wdata_b;
                            gnt_b       <= 1'b1;
                        end
                        state_q <= ACCESS;
                        busy    <= 1'b1;
                    end
                end

                ACCESS: begin
                    ram_en <= 1'b0;
                    if (we_q) begin
                        ack_a   <= (owner_q == REQ_A);
                        ack_b   <= (owner_q == REQ_B);
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    rdata    <= ram_dataout;
                    rvalid_a <= (owner_q == REQ_A);
                    rvalid_b <= (owner_q == REQ_B);
                    state_q  <= IDLE;
                    busy     <= 1'b0;
                end

                default: begin
                    ram_en  <= 1'b0;
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x8 registered-read RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [9:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, ack_a, rvalid_a, gnt_b, ack_b, rvalid_b;
    logic [7:0] rdata;
    logic       ram_en;
    logic [9:0] ram_address;
    logic [7:0] ram_datain;
    logic [7:0] ram_dataout;
    logic       busy;

    logic [7:0] mem [1024];

    int vectors;
    int miscompares;

    ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_a       (req_a),
        .we_a        (we_a),
        .addr_a      (addr_a),
        .wdata_a     (wdata_a),
        .gnt_a       (gnt_a),
        .ack_a       (ack_a),
        .rvalid_a    (rvalid_a),
        .req_b       (req_b),
        .we_b        (we_b),
        .addr_b      (addr_b),
        .wdata_b     (wdata_b),
        .gnt_b       (gnt_b),
        .ack_b       (ack_b),
        .rvalid_b    (rvalid_b),
        .rdata       (rdata),
        .ram_en      (ram_en),
        .ram_address (ram_address),
        .ram_datain  (ram_datain),
        .ram_dataout (ram_dataout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: en=1 writes, read data registered (1-cycle latency).
    always @(posedge clk) begin
        if (ram_en) mem[ram_address] <= ram_datain;
        ram_dataout <= mem[ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt_a, gnt_b}, 32'd0);
        check({tag, "_ack"}, {30'd0, ack_a, ack_b}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid_a, rvalid_b}, 32'd0);
        check({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ngnt;
        logic exp_b;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        tick();
        check_idle_outputs("reset");
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        check("reset_addr", {22'd0, ram_address}, 32'd0);
        check("reset_datain", {24'd0, ram_datain}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Reset asserted during A's ACCESS cycle abandons the write.
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd5; wdata_a = 8'h11;
        tick();
        check("midrst_gnt_a", {31'd0, gnt_a}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        req_a = 1'b0;
        rst   = 1'b0;
        #1;
        check_idle_outputs("midrst_async");
        check("midrst_addr", {22'd0, ram_address}, 32'd0);
        tick();
        check("midrst_no_ack", {31'd0, ack_a}, 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_no_ack2", {31'd0, ack_a}, 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        // A writes 800 = 50.
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd800; wdata_a = 8'd50;
        tick();
        check("w800_gnt_a", {30'd0, gnt_a, gnt_b}, 32'd2);
        check("w800_ram_en", {31'd0, ram_en}, 32'd1);
        check("w800_addr", {22'd0, ram_address}, 32'd800);
        check("w800_datain", {24'd0, ram_datain}, 32'd50);
        req_a = 1'b0;
        tick();
        check("w800_ack_a", {30'd0, ack_a, ack_b}, 32'd2);
        check("w800_ram_en_off", {31'd0, ram_en}, 32'd0);
        check("w800_busy_off", {31'd0, busy}, 32'd0);

        // A writes 900 = 60, then reads 800.
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd900; wdata_a = 8'd60;
        tick();
        check("w900_gnt_a", {31'd0, gnt_a}, 32'd1);
        req_a = 1'b0;
        tick();
        check("w900_ack_a", {31'd0, ack_a}, 32'd1);
        req_a = 1'b1; we_a = 1'b0; addr_a = 10'd800; wdata_a = 8'hff;
        tick();
        check("r800_gnt_a", {31'd0, gnt_a}, 32'd1);
        check("r800_ram_en_c1", {31'd0, ram_en}, 32'd0);
        check("r800_addr", {22'd0, ram_address}, 32'd800);
        req_a = 1'b0;
        tick();
        check("r800_ram_en_c2", {31'd0, ram_en}, 32'd0);
        check("r800_no_early_rvalid", {31'd0, rvalid_a}, 32'd0);
        check("r800_busy_capture", {31'd0, busy}, 32'd1);
        tick();
        check("r800_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd2);
        check("r800_rdata", {24'd0, rdata}, 32'd50);
        check("r800_no_ack", {31'd0, ack_a}, 32'd0);
        tick();
        check("r800_rvalid_pulse", {31'd0, rvalid_a}, 32'd0);
        check("r800_rdata_hold", {24'd0, rdata}, 32'd50);

        // From reset, A writes 800 = 7 and B reads 800 together.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd800; wdata_a = 8'd7;
        req_b = 1'b1; we_b = 1'b0; addr_b = 10'd800; wdata_b = 8'd0;
        tick();
        check("tie_first_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
        req_a = 1'b0;
        tick();
        check("tie_ack_a", {30'd0, ack_a, ack_b}, 32'd2);
        check("tie_b_waits", {31'd0, gnt_b}, 32'd0);
        tick();
        check("tie_gnt_b", {30'd0, gnt_a, gnt_b}, 32'd1);
        req_b = 1'b0;
        tick();
        check("tie_capture", {31'd0, rvalid_b}, 32'd0);
        tick();
        check("tie_rvalid_b", {30'd0, rvalid_a, rvalid_b}, 32'd1);
        check("tie_rdata", {24'd0, rdata}, 32'd7);
        tick();

        // Both requesters held high: grants must alternate A,B,...
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd1; wdata_a = 8'hA1;
        req_b = 1'b1; we_b = 1'b1; addr_b = 10'd2; wdata_b = 8'hB2;
        ngnt  = 0;
        exp_b = 1'b0;
        for (int c = 0; c < 24 && ngnt < 8; c++) begin
            tick();
            check("fair_two_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
            if (gnt_a || gnt_b) begin
                check("fair_order", {31'd0, gnt_b}, {31'd0, exp_b});
                exp_b = ~exp_b;
                ngnt++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check("fair_count", ngnt, 32'd8);
        tick();
        check("fair_last_ack_b", {30'd0, ack_a, ack_b}, 32'd1);
        tick();

        // B reads 900; A's request arrives during B's CAPTURE.
        req_b = 1'b1; we_b = 1'b0; addr_b = 10'd900;
        tick();
        check("late_gnt_b", {30'd0, gnt_a, gnt_b}, 32'd1);
        req_b = 1'b0;
        tick();
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd3; wdata_a = 8'd9;
        tick();
        check("late_rvalid_b", {30'd0, rvalid_a, rvalid_b}, 32'd1);
        check("late_rdata", {24'd0, rdata}, 32'd60);
        check("late_no_gnt_yet", {31'd0, gnt_a}, 32'd0);
        tick();
        check("late_gnt_a", {30'd0, gnt_a, gnt_b}, 32'd2);
        check("late_addr", {22'd0, ram_address}, 32'd3);
        req_a = 1'b0;
        tick();
        check("late_ack_a", {31'd0, ack_a}, 32'd1);
        check("late_rdata_hold", {24'd0, rdata}, 32'd60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
